// File: rtl/conway_pkg.sv
// rtl/conway_pkg.sv - shared command/state encodings for the Game-of-Life engine
package conway_pkg;

  // Host command codes presented with cmd_valid.
  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_LOAD   = 2'b01,
    CMD_RUN    = 2'b10,
    CMD_UNLOAD = 2'b11
  } cmd_e;

  // FSM states; the encoding doubles as the debug LED code.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_RUN    = 2'b10,
    ST_UNLOAD = 2'b11
  } state_e;

endpackage

// File: rtl/conway_serial_engine_if.sv
// rtl/conway_serial_engine_if.sv - host-side command, serial data and status bundle
interface conway_serial_engine_if
  import conway_pkg::*;
#(
  parameter int GEN_WIDTH = 16
);

  cmd_e                 cmd;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [GEN_WIDTH-1:0] gen_limit;
  logic                 abort;
  logic                 data_in;
  logic                 data_in_valid;
  logic                 data_out;
  logic                 data_out_valid;
  logic                 data_out_ready;
  logic [GEN_WIDTH-1:0] gen_count;
  logic                 stable;
  logic                 extinct;
  logic                 busy;
  logic                 done;
  logic [1:0]           state_leds;

  // Host / bridge side.
  modport master (
    output cmd, cmd_valid, gen_limit, abort, data_in, data_in_valid, data_out_ready,
    input  cmd_ready, data_out, data_out_valid, gen_count, stable, extinct, busy, done,
           state_leds
  );

  // Engine side.
  modport slave (
    input  cmd, cmd_valid, gen_limit, abort, data_in, data_in_valid, data_out_ready,
    output cmd_ready, data_out, data_out_valid, gen_count, stable, extinct, busy, done,
           state_leds
  );

endinterface

// File: rtl/cell_grid.sv
// rtl/cell_grid.sv - combinational Game-of-Life next-generation compute with dead borders
module cell_grid #(
  parameter int GRID_WIDTH  = 8,
  parameter int GRID_HEIGHT = 8
) (
  input  logic [GRID_WIDTH*GRID_HEIGHT-1:0] grid,
  output logic [GRID_WIDTH*GRID_HEIGHT-1:0] next_state
);

  localparam int PW = GRID_WIDTH + 2;
  localparam int PH = GRID_HEIGHT + 2;

  // One-cell ring of permanently dead cells keeps every neighbour index in range.
  logic [PW*PH-1:0] padded;

  // Embed the grid into the dead-bordered frame.
  always_comb begin
    padded = '0;
    for (int r = 0; r < GRID_HEIGHT; r++) begin
      for (int c = 0; c < GRID_WIDTH; c++) begin
        padded[(r+1)*PW + (c+1)] = grid[r*GRID_WIDTH + c];
      end
    end
  end

  // Count the eight neighbours of each cell and apply birth-on-3 / survive-on-2-or-3.
  always_comb begin : p_step
    logic [3:0] n;
    n          = '0;
    next_state = '0;
    for (int r = 0; r < GRID_HEIGHT; r++) begin
      for (int c = 0; c < GRID_WIDTH; c++) begin
        n = '0;
        for (int dr = 0; dr < 3; dr++) begin
          for (int dc = 0; dc < 3; dc++) begin
            if (!(dr == 1 && dc == 1)) begin
              n = n + 4'(padded[(r+dr)*PW + (c+dc)]);
            end
          end
        end
        next_state[r*GRID_WIDTH + c] = (n == 4'd3) || (grid[r*GRID_WIDTH + c] && (n == 4'd2));
      end
    end
  end

endmodule

// File: rtl/conway_serial_engine.sv
// rtl/conway_serial_engine.sv - grid storage, command FSM, serial load/unload and run sequencing
module conway_serial_engine
  import conway_pkg::*;
#(
  parameter int GRID_WIDTH  = 8,
  parameter int GRID_HEIGHT = 8,
  parameter int GEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  conway_serial_engine_if.slave bus
);

  localparam int                DATA_SIZE = GRID_WIDTH * GRID_HEIGHT;
  localparam int                CNT_W     = $clog2(DATA_SIZE + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_SIZE - 1);

  state_e                 state_q, state_d;
  logic [DATA_SIZE-1:0]   grid_q, grid_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GEN_WIDTH-1:0]   gen_q, gen_d;
  logic [GEN_WIDTH-1:0]   limit_q, limit_d;
  logic                   stable_q, stable_d;
  logic                   extinct_q, extinct_d;
  logic                   done_q, done_d;
  logic [DATA_SIZE-1:0]   next_state;

  cell_grid #(
    .GRID_WIDTH (GRID_WIDTH),
    .GRID_HEIGHT(GRID_HEIGHT)
  ) u_cell_grid (
    .grid      (grid_q),
    .next_state(next_state)
  );

  // State, grid and counter registers; async reset returns everything to the idle, empty grid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      grid_q    <= '0;
      cnt_q     <= '0;
      gen_q     <= '0;
      limit_q   <= '0;
      stable_q  <= 1'b0;
      extinct_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grid_q    <= grid_d;
      cnt_q     <= cnt_d;
      gen_q     <= gen_d;
      limit_q   <= limit_d;
      stable_q  <= stable_d;
      extinct_q <= extinct_d;
      done_q    <= done_d;
    end
  end

  // Next-state: command decode, serial shift/rotate and generation stepping; abort wins over all.
  always_comb begin
    state_d  = state_q;
    grid_d   = grid_q;
    cnt_d    = cnt_q;
    gen_d    = gen_q;
    limit_d  = limit_q;
    stable_d = stable_q;
    done_d   = 1'b0;

    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            cnt_d = '0;
            case (bus.cmd)
              CMD_LOAD:   state_d = ST_LOAD;
              CMD_RUN: begin
                state_d  = ST_RUN;
                gen_d    = '0;
                stable_d = 1'b0;
                limit_d  = bus.gen_limit;
              end
              CMD_UNLOAD: state_d = ST_UNLOAD;
              default:    state_d = ST_IDLE;
            endcase
          end
        end
        ST_LOAD: begin
          if (bus.data_in_valid) begin
            grid_d = {bus.data_in, grid_q[DATA_SIZE-1:1]};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (gen_q == limit_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (next_state == grid_q) begin
            stable_d = 1'b1;
            state_d  = ST_IDLE;
            done_d   = 1'b1;
          end else begin
            grid_d = next_state;
            gen_d  = gen_q + GEN_WIDTH'(1);
          end
        end
        ST_UNLOAD: begin
          if (bus.data_out_ready) begin
            grid_d = {grid_q[0], grid_q[DATA_SIZE-1:1]};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    extinct_d = (grid_d == '0);
  end

  // Outputs decoded from registered state; data_out only presents a cell while unloading.
  always_comb begin
    bus.cmd_ready      = (state_q == ST_IDLE);
    bus.busy           = (state_q != ST_IDLE);
    bus.data_out_valid = (state_q == ST_UNLOAD);
    bus.data_out       = (state_q == ST_UNLOAD) ? grid_q[0] : 1'b0;
    bus.gen_count      = gen_q;
    bus.stable         = stable_q;
    bus.extinct        = extinct_q;
    bus.done           = done_q;
    bus.state_leds     = state_q;
  end

endmodule

// File: tb/tb_conway_serial_engine.sv
// tb/tb_conway_serial_engine.sv - randomized self-checking bench with a behavioural Life model
module tb_conway_serial_engine;
  import conway_pkg::*;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int DS = W * H;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  int   done_cnt;

  conway_serial_engine_if #(.GEN_WIDTH(16)) bus ();

  conway_serial_engine #(
    .GRID_WIDTH (W),
    .GRID_HEIGHT(H),
    .GEN_WIDTH  (16)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (bus.done === 1'b1) done_cnt++;
  end

  function automatic logic [DS-1:0] life_step(input logic [DS-1:0] g);
    logic [DS-1:0] n;
    int k;
    n = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        k = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
              k += int'(g[(r + dr) * W + (c + dc)]);
          end
        end
        n[r * W + c] = (k == 3) || (g[r * W + c] && k == 2);
      end
    end
    return n;
  endfunction

  function automatic logic [DS-1:0] rand_grid();
    logic [DS-1:0] g;
    for (int i = 0; i < DS; i++) g[i] = ($urandom_range(2) == 0);
    return g;
  endfunction

  task automatic send_cmd(input cmd_e c, input logic [15:0] lim);
    bus.cmd       = c;
    bus.gen_limit = lim;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd       = CMD_NOP;
  endtask

  task automatic load_grid(input logic [DS-1:0] g);
    send_cmd(CMD_LOAD, 16'd0);
    for (int i = 0; i < DS; i++) begin
      bus.data_in       = g[i];
      bus.data_in_valid = 1'b1;
      @(negedge clk);
    end
    bus.data_in_valid = 1'b0;
  endtask

  task automatic unload_grid(input bit toggle, output logic [DS-1:0] got, output int n,
                             output int hold_errs, output int early);
    int   d0;
    logic pv, pr, pd, r;
    d0 = done_cnt;
    n = 0; hold_errs = 0; early = 0; got = '0;
    pv = 1'b0; pr = 1'b1; pd = 1'b0;
    send_cmd(CMD_UNLOAD, 16'd0);
    for (int cyc = 0; cyc < 400 && n < DS; cyc++) begin
      r = toggle ? ((cyc % 2) == 0) : 1'b1;
      bus.data_out_ready = r;
      if (pv && !pr && bus.data_out !== pd) hold_errs++;
      if (done_cnt != d0) early++;
      if (bus.data_out_valid === 1'b1 && r) begin
        got[n] = bus.data_out;
        n++;
      end
      pv = bus.data_out_valid; pr = r; pd = bus.data_out;
      @(negedge clk);
    end
    bus.data_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [DS-1:0] got;
    int n, he, ea;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.data_out !== 1'b0 || bus.data_out_valid !== 1'b0) begin bad++; $display("FAIL reset_data_out got=%b/%b exp=0/0", bus.data_out, bus.data_out_valid); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.state_leds !== 2'b00) begin bad++; $display("FAIL reset_leds got=%b exp=00", bus.state_leds); end
    total++; if (bus.gen_count !== 16'd0 || bus.stable !== 1'b0) begin bad++; $display("FAIL reset_gen got=%0d/%b exp=0/0", bus.gen_count, bus.stable); end
    total++; if (bus.extinct !== 1'b1) begin bad++; $display("FAIL reset_extinct got=%b exp=1", bus.extinct); end
    reset_n = 1'b1;
    @(negedge clk);
    unload_grid(1'b0, got, n, he, ea);
    total++; if (got !== '0 || n != DS) begin bad++; $display("FAIL reset_grid got=%h n=%0d exp=0 n=%0d", got, n, DS); end
  endtask

  task automatic test_load_unload(input logic [DS-1:0] g, input string nm);
    logic [DS-1:0] got;
    int n, he, ea, d0;
    d0 = done_cnt;
    load_grid(g);
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL %s_load_done got=%0d exp=1", nm, done_cnt - d0); end
    total++; if (bus.extinct !== (g == '0)) begin bad++; $display("FAIL %s_extinct got=%b exp=%b", nm, bus.extinct, (g == '0)); end
    d0 = done_cnt;
    unload_grid(1'b0, got, n, he, ea);
    total++; if (got !== g || n != DS) begin bad++; $display("FAIL %s_unload got=%h exp=%h n=%0d", nm, got, g, n); end
    total++; if (done_cnt - d0 != 1 || ea != 0) begin bad++; $display("FAIL %s_unload_done got=%0d early=%0d exp=1/0", nm, done_cnt - d0, ea); end
    unload_grid(1'b0, got, n, he, ea);
    total++; if (got !== g) begin bad++; $display("FAIL %s_restored got=%h exp=%h", nm, got, g); end
  endtask

  task automatic test_run_case(input logic [DS-1:0] g, input logic [15:0] lim, input string nm,
                               output logic [DS-1:0] got, output int gen_o, output bit stab_o);
    logic [DS-1:0] mg, nx;
    int  eg, cyc, n, he, ea, d0;
    bit  es;
    mg = g; eg = 0; es = 1'b0;
    while (1) begin
      if (eg == int'(lim)) break;
      nx = life_step(mg);
      if (nx == mg) begin es = 1'b1; break; end
      mg = nx;
      eg++;
    end
    load_grid(g);
    d0 = done_cnt;
    send_cmd(CMD_RUN, lim);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < int'(lim) + 200) begin
      cyc++;
      @(negedge clk);
    end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s_timeout busy still high after %0d cycles", nm, cyc); end
    total++; if (cyc != eg + 1) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", nm, cyc, eg + 1); end
    total++; if (int'(bus.gen_count) != eg) begin bad++; $display("FAIL %s_gen_count got=%0d exp=%0d", nm, bus.gen_count, eg); end
    total++; if (bus.stable !== es) begin bad++; $display("FAIL %s_stable got=%b exp=%b", nm, bus.stable, es); end
    total++; if (bus.extinct !== (mg == '0)) begin bad++; $display("FAIL %s_extinct got=%b exp=%b", nm, bus.extinct, (mg == '0)); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL %s_run_done got=%0d exp=1", nm, done_cnt - d0); end
    unload_grid(1'b0, got, n, he, ea);
    total++; if (got !== mg) begin bad++; $display("FAIL %s_grid got=%h exp=%h", nm, got, mg); end
    gen_o  = int'(bus.gen_count);
    stab_o = bus.stable;
  endtask

  task automatic test_patterns();
    logic [DS-1:0] g, got;
    int gc;
    bit st;
    g = '0; g[9] = 1'b1; g[10] = 1'b1; g[11] = 1'b1;
    test_run_case(g, 16'd3, "blinker", got, gc, st);
    total++; if (got !== 64'h0000_0000_0004_0404 || gc != 3 || st) begin bad++; $display("FAIL blinker_fixed got=%h/%0d/%b exp=40404/3/0", got, gc, st); end
    g = '0; g[0] = 1'b1; g[1] = 1'b1; g[8] = 1'b1; g[9] = 1'b1;
    test_run_case(g, 16'd100, "block", got, gc, st);
    total++; if (got !== g || gc != 0 || !st) begin bad++; $display("FAIL block_fixed got=%h/%0d/%b exp=%h/0/1", got, gc, st, g); end
    g = '0; g[27] = 1'b1;
    test_run_case(g, 16'd5, "single", got, gc, st);
    total++; if (got !== '0 || gc != 1 || !st || bus.extinct !== 1'b1) begin bad++; $display("FAIL single_fixed got=%h/%0d/%b/%b exp=0/1/1/1", got, gc, st, bus.extinct); end
    g = rand_grid();
    test_run_case(g, 16'd0, "limit0", got, gc, st);
  endtask

  task automatic test_random_runs();
    logic [DS-1:0] got;
    int gc;
    bit st;
    for (int i = 0; i < 5; i++) test_run_case(rand_grid(), 16'($urandom_range(12)), "random", got, gc, st);
  endtask

  task automatic test_unload_stall();
    logic [DS-1:0] g, got;
    int n, he, ea, d0;
    g = rand_grid();
    load_grid(g);
    d0 = done_cnt;
    unload_grid(1'b1, got, n, he, ea);
    total++; if (got !== g || n != DS) begin bad++; $display("FAIL stall_data got=%h exp=%h n=%0d", got, g, n); end
    total++; if (he != 0) begin bad++; $display("FAIL stall_hold changed=%0d exp=0", he); end
    total++; if (ea != 0 || done_cnt - d0 != 1) begin bad++; $display("FAIL stall_done early=%0d total=%0d exp=0/1", ea, done_cnt - d0); end
  endtask

  task automatic test_abort();
    logic [DS-1:0] g, got;
    int n, he, ea, d0;
    bit b;
    g = rand_grid();
    load_grid(g);
    d0 = done_cnt;
    send_cmd(CMD_LOAD, 16'd0);
    for (int i = 0; i < 20; i++) begin
      b = 1'($urandom_range(1));
      bus.data_in = b; bus.data_in_valid = 1'b1;
      g = {b, g[DS-1:1]};
      @(negedge clk);
    end
    bus.data_in_valid = 1'b0;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.state_leds !== 2'b00) begin bad++; $display("FAIL abort_idle got=%b/%b exp=0/00", bus.busy, bus.state_leds); end
    @(negedge clk);
    total++; if (done_cnt != d0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt - d0); end
    unload_grid(1'b0, got, n, he, ea);
    total++; if (got !== g) begin bad++; $display("FAIL abort_grid got=%h exp=%h", got, g); end
  endtask

  task automatic test_cmd_busy();
    logic [DS-1:0] g, got;
    int n, he, ea, cyc;
    g = '0; g[9] = 1'b1; g[10] = 1'b1; g[11] = 1'b1;
    load_grid(g);
    send_cmd(CMD_RUN, 16'd40);
    repeat (2) @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL busy_cmd_ready got=%b exp=0", bus.cmd_ready); end
    bus.cmd = CMD_UNLOAD; bus.cmd_valid = 1'b1; bus.data_in_valid = 1'b1; bus.data_in = 1'b1;
    repeat (2) @(negedge clk);
    bus.cmd_valid = 1'b0; bus.cmd = CMD_NOP; bus.data_in_valid = 1'b0;
    total++; if (bus.state_leds !== 2'b10) begin bad++; $display("FAIL busy_state got=%b exp=10", bus.state_leds); end
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin cyc++; @(negedge clk); end
    total++; if (bus.gen_count !== 16'd40 || bus.busy !== 1'b0) begin bad++; $display("FAIL busy_run got=%0d/%b exp=40/0", bus.gen_count, bus.busy); end
    bus.data_in = 1'b1; bus.data_in_valid = 1'b1;
    repeat (5) @(negedge clk);
    bus.data_in_valid = 1'b0;
    unload_grid(1'b0, got, n, he, ea);
    total++; if (got !== g) begin bad++; $display("FAIL idle_data_in got=%h exp=%h", got, g); end
  endtask

  task automatic test_reset_mid_run();
    logic [DS-1:0] g, got;
    int n, he, ea, d0;
    g = '0; g[9] = 1'b1; g[10] = 1'b1; g[11] = 1'b1;
    load_grid(g);
    d0 = done_cnt;
    send_cmd(CMD_RUN, 16'd40);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++; if (bus.state_leds !== 2'b00 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_state got=%b/%b/%b exp=00/0/1", bus.state_leds, bus.busy, bus.cmd_ready); end
    total++; if (bus.gen_count !== 16'd0 || bus.stable !== 1'b0 || bus.extinct !== 1'b1) begin bad++; $display("FAIL rst_mid_status got=%0d/%b/%b exp=0/0/1", bus.gen_count, bus.stable, bus.extinct); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (done_cnt != d0) begin bad++; $display("FAIL rst_mid_done got=%0d exp=0", done_cnt - d0); end
    unload_grid(1'b0, got, n, he, ea);
    total++; if (got !== '0) begin bad++; $display("FAIL rst_mid_grid got=%h exp=0", got); end
  endtask

  initial begin
    total = 0; bad = 0; done_cnt = 0;
    reset_n = 1'b0;
    bus.cmd = CMD_NOP; bus.cmd_valid = 1'b0; bus.gen_limit = '0; bus.abort = 1'b0;
    bus.data_in = 1'b0; bus.data_in_valid = 1'b0; bus.data_out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_load_unload({8{8'hA5}}, "a5");
    test_load_unload(rand_grid(), "rnd");
    test_patterns();
    test_random_runs();
    test_unload_stall();
    test_abort();
    test_cmd_busy();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
